minterm_response_checker: RTL

Self-checking response monitor for the 4-input sum-of-minterms logic blocks. It consumes (input vector, DUT output) samples over a valid/ready handshake and compares each output against a parameterised minterm mask. It accumulates mismatch count, first-failure vector and input-space coverage, and reports pass/fail once all 16 vectors have been seen. It sits at the receiving end of the stimulus path: a generator drives the DUT, and this block judges the responses in hardware rather than by waveform or monitor inspection.

---
 rtl/minterm_response_checker.sv | 80 ++++++++
 1 files changed

// File: rtl/minterm_response_checker.sv
// rtl/minterm_response_checker.sv - checks 4-input minterm block responses and gathers coverage/error stats
module minterm_response_checker #(
  parameter logic [15:0] MINTERMS = 16'hDF03,
  parameter int          ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_vec,
  input  logic             in_resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       first_err_vec,
  output logic             first_err_valid,
  output logic [15:0]      coverage
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic        accept;
  logic        fail;
  logic [15:0] cov_next;

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign pass     = (state == DONE) && (err_cnt == '0);

  // start wins over a sample presented in the same cycle
  always_comb begin
    accept   = 1'b0;
    fail     = 1'b0;
    cov_next = coverage;
    if (!start && state == RUN && in_valid) begin
      accept   = 1'b1;
      fail     = (in_resp != MINTERMS[in_vec]);
      cov_next = coverage | (16'b1 << in_vec);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      mismatch        <= 1'b0;
      err_cnt         <= '0;
      first_err_vec   <= 4'd0;
      first_err_valid <= 1'b0;
      coverage        <= 16'd0;
    end else begin
      mismatch <= 1'b0;
      if (start) begin
        state           <= RUN;
        err_cnt         <= '0;
        first_err_vec   <= 4'd0;
        first_err_valid <= 1'b0;
        coverage        <= 16'd0;
      end else if (accept) begin
        coverage <= cov_next;
        if (fail) begin
          mismatch <= 1'b1;
          if (err_cnt != '1)
            err_cnt <= err_cnt + 1'b1;
          if (!first_err_valid) begin
            first_err_vec   <= in_vec;
            first_err_valid <= 1'b1;
          end
        end
        if (cov_next == 16'hFFFF)
          state <= DONE;
      end
    end
  end

endmodule
